// File: rtl/hc4_banked_ram.sv
// Banked, clocked RAM on a shared tri-state bus with active-low RD/WR strobes.
// After reset a sequencer zeroes the array (optional) before raising ready.
module hc4_banked_ram #(
   parameter int DATA_W         = 4,
   parameter int ADDR_W         = 4,
   parameter int BANK_W         = 2,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic [BANK_W-1:0] bank,
   input  logic [ADDR_W-1:0] address,
   inout  wire  [DATA_W-1:0] data_bus,
   input  logic              nRAM_RD,
   input  logic              nRAM_WR,
   output logic              ready
);

   localparam int IDX_W = BANK_W + ADDR_W;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   typedef enum logic {S_CLEAR, S_IDLE} state_e;

   state_e             state_q;
   logic [IDX_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   cnt_d;
   logic               wr_prev_q;
   logic               ready_q;
   logic [DATA_W-1:0]  mem_q [DEPTH];

   logic [IDX_W-1:0]   idx;
   logic               wr_fire;
   logic               clr_fire;
   logic               rd_oe;

   assign idx   = {bank, address};
   assign cnt_d = cnt_q + 1'b1;

   // Falling edge of the write strobe only, so a held strobe writes once.
   // nReset gates both write paths so edges seen during reset cannot touch the array.
   assign wr_fire  = nReset && (state_q == S_IDLE) && !nRAM_WR && wr_prev_q;
   assign clr_fire = CLEAR_ON_RESET && nReset && (state_q == S_CLEAR);

   // Write strobe wins over read: never drive while the core may be driving.
   assign rd_oe    = ready_q && !nRAM_RD && nRAM_WR;
   assign data_bus = rd_oe ? mem_q[idx] : {DATA_W{1'bz}};
   assign ready    = ready_q;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q   <= S_CLEAR;
         cnt_q     <= '0;
         wr_prev_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         wr_prev_q <= nRAM_WR;
         case (state_q)
            S_CLEAR: begin
               if (!CLEAR_ON_RESET || (cnt_q == LAST_IDX)) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_IDLE: ;
            default: state_q <= S_CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire)
         mem_q[idx] <= data_bus;
      else if (clr_fire)
         mem_q[cnt_q] <= '0;
   end

endmodule

// File: tb/tb_hc4_banked_ram.sv
// Scoreboarded bench for hc4_banked_ram: default instance plus a no-clear 8-bit instance.
module tb_hc4_banked_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic       nReset, nRAM_RD, nRAM_WR, ready;
   logic [1:0] bank;
   logic [3:0] address;
   wire  [3:0] data_bus;
   logic       tb_oe;
   logic [3:0] tb_dat;
   assign data_bus = tb_oe ? tb_dat : 4'bz;

   hc4_banked_ram dut (
      .clk(clk), .nReset(nReset), .bank(bank), .address(address),
      .data_bus(data_bus), .nRAM_RD(nRAM_RD), .nRAM_WR(nRAM_WR), .ready(ready)
   );

   // no-clear instance
   logic       b_rst_n, b_rd, b_wr, b_ready;
   logic [0:0] b_bank;
   logic [2:0] b_addr;
   wire  [7:0] b_bus;
   logic       b_oe;
   logic [7:0] b_dat;
   assign b_bus = b_oe ? b_dat : 8'bz;

   hc4_banked_ram #(.DATA_W(8), .ADDR_W(3), .BANK_W(1), .CLEAR_ON_RESET(1'b0)) dut_b (
      .clk(clk), .nReset(b_rst_n), .bank(b_bank), .address(b_addr),
      .data_bus(b_bus), .nRAM_RD(b_rd), .nRAM_WR(b_wr), .ready(b_ready)
   );

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [3:0] model [64];
   logic [3:0] exp_q [$];
   logic [3:0] mon_exp;
   bit         mon_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle the bench holds a read strobe, the bus must match the next queued word.
   always @(posedge clk) begin
      #1;
      if (mon_en && !nRAM_RD && nRAM_WR) begin
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: read observed %0h with no expectation", data_bus);
         end else begin
            mon_exp = exp_q.pop_front();
            n_chk++;
            if (data_bus !== mon_exp) begin
               n_fail++;
               $display("FAIL sb_read: addr %0h got %0h expected %0h at %0t",
                        {bank, address}, data_bus, mon_exp, $time);
            end
         end
      end
   end

   always @(posedge clk)
      if (nReset && !nRAM_WR && $isunknown({bank, address})) begin
         n_fail++;
         $display("FAIL x_addr_on_write: bank/address unknown at %0t", $time);
      end

   task automatic write(input logic [1:0] b, input logic [3:0] a, input logic [3:0] d);
      @(negedge clk);
      bank = b; address = a; tb_dat = d; tb_oe = 1'b1; nRAM_WR = 1'b0;
      model[{b, a}] = d;
      @(negedge clk);
      nRAM_WR = 1'b1; tb_oe = 1'b0;
   endtask

   // Holds the read strobe across n cycles, stepping the address each cycle.
   task automatic read_burst(input int first, input int n);
      logic [5:0] ix;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ix = 6'(first + i);
         {bank, address} = ix;
         nRAM_RD = 1'b0;
         exp_q.push_back(model[ix]);
      end
      @(negedge clk);
      nRAM_RD = 1'b1;
   endtask

   task automatic wait_ready(input string nm);
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk); #1;
         chk(nm, 32'(ready), 32'(i == 64));
      end
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      logic [5:0] ridx;
      nReset = 1'b0; nRAM_RD = 1'b1; nRAM_WR = 1'b1; bank = '0; address = '0;
      tb_oe = 1'b0; tb_dat = '0; mon_en = 1'b1;
      b_rst_n = 1'b0; b_rd = 1'b1; b_wr = 1'b1; b_bank = '0; b_addr = '0; b_oe = 1'b0; b_dat = '0;
      for (int i = 0; i < 64; i++) model[i] = '0;

      repeat (2) @(negedge clk);
      #1 chk("reset_ready", 32'(ready), 0);

      // power-on clear
      @(negedge clk);
      nReset = 1'b1;
      wait_ready("ready_clear");
      read_burst(0, 64);

      // banked write/read
      write(2'd0, 4'd3, 4'hA);
      write(2'd2, 4'd3, 4'h5);
      read_burst(6'h03, 1);
      read_burst(6'h23, 1);
      read_burst(6'h13, 1);

      // one write per strobe
      @(negedge clk);
      bank = 2'd1; address = 4'd9; tb_dat = 4'd1; tb_oe = 1'b1; nRAM_WR = 1'b0;
      model[6'h19] = 4'd1;
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         tb_dat = 4'(k);
      end
      @(negedge clk);
      nRAM_WR = 1'b1; tb_oe = 1'b0;
      read_burst(6'h19, 1);
      write(2'd1, 4'd9, 4'd7);
      read_burst(6'h19, 1);

      // contention: write wins, DUT stays off the bus
      write(2'd3, 4'd2, 4'h3);
      @(negedge clk);
      bank = 2'd3; address = 4'd2; tb_dat = 4'hC; tb_oe = 1'b1;
      nRAM_RD = 1'b0; nRAM_WR = 1'b0;
      model[6'h32] = 4'hC;
      #1 chk("contention_bus_pre", 32'(data_bus), 32'hC);
      repeat (2) begin
         @(posedge clk); #1;
         chk("contention_bus", 32'(data_bus), 32'hC);
      end
      @(negedge clk);
      nRAM_RD = 1'b1; nRAM_WR = 1'b1; tb_oe = 1'b0;
      read_burst(6'h32, 1);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         ridx = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) write(ridx[5:4], ridx[3:0], 4'($urandom));
         else read_burst(int'(ridx), 1);
      end

      // reset mid-operation, mid-clear, and a strobe held across ready
      write(2'd3, 4'd15, 4'hF);
      @(negedge clk);
      mon_en = 1'b0;
      bank = 2'd3; address = 4'd15; nRAM_RD = 1'b0;
      #1 chk("pre_reset_read", 32'(data_bus), 32'hF);
      nReset = 1'b0; tb_dat = 4'h0; tb_oe = 1'b1;
      #1 chk("reset_bus_released", 32'(data_bus), 0);
      chk("reset_ready_drop", 32'(ready), 0);
      @(negedge clk);
      nReset = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         chk("midclear_ready", 32'(ready), 0);
         chk("midclear_bus", 32'(data_bus), 0);
      end
      @(negedge clk);
      nReset = 1'b0;
      #1 chk("midclear_reset_ready", 32'(ready), 0);
      nRAM_RD = 1'b1;
      bank = 2'd1; address = 4'd5; tb_dat = 4'h9; nRAM_WR = 1'b0;
      @(negedge clk);
      nReset = 1'b1;
      wait_ready("ready_reclear");
      repeat (3) @(posedge clk);
      @(negedge clk);
      nRAM_WR = 1'b1; tb_oe = 1'b0;
      for (int i = 0; i < 64; i++) model[i] = '0;
      mon_en = 1'b1;
      read_burst(0, 64);

      // no-clear, narrow-address, 8-bit instance
      @(negedge clk);
      b_rst_n = 1'b1;
      #1 chk("b_ready_before_edge", 32'(b_ready), 0);
      @(posedge clk); #1;
      chk("b_ready_first_edge", 32'(b_ready), 1);
      @(negedge clk);
      b_bank = 1'b1; b_addr = 3'd7; b_dat = 8'hE7; b_oe = 1'b1; b_wr = 1'b0;
      @(negedge clk);
      b_wr = 1'b1; b_oe = 1'b0;
      @(negedge clk);
      b_rd = 1'b0;
      #1 chk("b_read_e7", 32'(b_bus), 32'hE7);
      b_rd = 1'b1; b_rst_n = 1'b0;
      #1 chk("b_reset_ready", 32'(b_ready), 0);
      @(negedge clk);
      b_rst_n = 1'b1;
      @(posedge clk); #1;
      chk("b_ready_rerelease", 32'(b_ready), 1);
      @(negedge clk);
      b_rd = 1'b0;
      #1 chk("b_retained_e7", 32'(b_bus), 32'hE7);
      b_rd = 1'b1;

      repeat (3) @(negedge clk);
      chk("sb_drain", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
